// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one external shift-add multiplier among NREQ requesters.
// Optional RUN-state watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int BW      = (((2 * N) / 3) + 1) * 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [2*N-1:0]      resp_out,
  output logic [BW-1:0]       resp_bcd,
  output logic                resp_err,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  output logic                mul_start,
  input  logic                mul_finish,
  input  logic [2*N-1:0]      mul_out,
  input  logic [BW-1:0]       mul_bcd
);

  if (NREQ < 2 || NREQ > 16 || (1 << IDW) < NREQ || TIMEOUT < 2) begin : g_bad_params
    $error("mul_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           run_first;
  logic           fin_ok;
  logic           timed_out;
  int             idx;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  // A finish already high on the first RUN cycle is stale from the previous job.
  assign fin_ok = (state == RUN) && mul_finish && !run_first;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign timed_out = (state == RUN) && (to_cnt == CW'(TIMEOUT - 1));
  assign resp_err  = err_q;
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_id] = 1'b1;
          state_nxt         = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (fin_ok || timed_out) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_start  = (state == RUN);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      resp_id   <= '0;
      resp_out  <= '0;
      resp_bcd  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      run_first <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      run_first <= (state == LOAD);

      if (state == IDLE && gnt_found) begin
        mul_a   <= req_a[int'(gnt_id)*N +: N];
        mul_b   <= req_b[int'(gnt_id)*N +: N];
        resp_id <= gnt_id;
        ptr     <= IDW'((int'(gnt_id) + 1) % NREQ);
      end

      if (fin_ok) begin
        resp_out <= mul_out;
        resp_bcd <= mul_bcd;
`ifdef MUL_ARB_TIMEOUT_EN
        err_q    <= 1'b0;
      end else if (timed_out) begin
        resp_out <= '0;
        resp_bcd <= '0;
        err_q    <= 1'b1;
`endif
      end

`ifdef MUL_ARB_TIMEOUT_EN
      if (state == LOAD)     to_cnt <= '0;
      else if (state == RUN) to_cnt <= to_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a behavioural multiplier model.
// Timeout expectations follow MUL_ARB_TIMEOUT_EN.
module tb_mul_arbiter;
  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int BW   = (((2 * N) / 3) + 1) * 4;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*N-1:0]    resp_out;
  logic [BW-1:0]     resp_bcd;
  logic              resp_err;
  logic [N-1:0]      mul_a, mul_b;
  logic              mul_start, mul_finish;
  logic [2*N-1:0]    mul_out;
  logic [BW-1:0]     mul_bcd;

  always #5 clk = ~clk;

  mul_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .BW(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_bcd(resp_bcd), .resp_err(resp_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_finish(mul_finish),
    .mul_out(mul_out), .mul_bcd(mul_bcd)
  );

  // External multiplier: loads while start is low, finishes N cycles after start.
  logic [N-1:0] ma, mb;
  int           mcnt;
  bit           mul_hang  = 1'b0;
  bit           mul_stale = 1'b0;

  function automatic logic [BW-1:0] to_bcd(input logic [2*N-1:0] v);
    logic [BW-1:0] r;
    int            x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < BW / 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mul_start) begin
      ma   <= mul_a;
      mb   <= mul_b;
      mcnt <= 0;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  assign mul_out    = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
  assign mul_bcd    = to_bcd(mul_out);
  assign mul_finish = mul_start && !mul_hang && (mul_stale || mcnt >= N);

  int checks = 0;
  int errors = 0;

  int             got_gnt[16];
  int             got_id[16];
  logic [2*N-1:0] got_out[16];
  logic [BW-1:0]  got_bcd[16];
  logic           got_err[16];
  int             pulses[NREQ];
  int             n_gnt, n_resp;

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*N +: N]    = a;
    req_b[i*N +: N]    = b;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Runs from drive phase (posedge+1) until njobs responses are consumed or budget expires.
  task automatic collect(input int njobs, input int budget);
    logic [NREQ-1:0] clr;
    n_gnt  = 0;
    n_resp = 0;
    for (int i = 0; i < 16; i++) begin
      got_gnt[i] = -1;
      got_id[i]  = -1;
    end
    for (int i = 0; i < NREQ; i++) pulses[i] = 0;
    for (int c = 0; c < budget && n_resp < njobs; c++) begin
      @(negedge clk);
      clr = '0;
      if (req_ready != '0) begin
        got_gnt[n_gnt] = idx_of(req_ready);
        n_gnt++;
        for (int i = 0; i < NREQ; i++) pulses[i] += int'(req_ready[i]);
        clr = req_ready;
      end
      if (resp_valid && resp_ready) begin
        got_id[n_resp]  = int'(resp_id);
        got_out[n_resp] = resp_out;
        got_bcd[n_resp] = resp_bcd;
        got_err[n_resp] = resp_err;
        n_resp++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~clr;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_out, resp_bcd, resp_err, mul_a, mul_b, mul_start} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b id=%0d out=%0d bcd=%h err=%b a=%0d b=%0d st=%b want all zero",
               req_ready, resp_valid, resp_id, resp_out, resp_bcd, resp_err, mul_a, mul_b, mul_start);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int lat, extra;
    lat = -1;
    extra = 0;
    set_req(2, 8'd13, 8'd11);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b want 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_ready !== '0) extra++;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 3 + N) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, 3 + N); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL single_ready_pulses got %0d extra want 0", extra); end
    checks++;
    if (resp_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", resp_id); end
    checks++;
    if (resp_out !== 16'd143) begin errors++; $display("FAIL single_out got %0d want 143", resp_out); end
    checks++;
    if (resp_bcd !== 24'h000143) begin errors++; $display("FAIL single_bcd got %h want 000143", resp_bcd); end
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", resp_err); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b want 0", resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_four();
    logic [2*N-1:0] exp_out[4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [BW-1:0]  exp_bcd[4] = '{24'h10, 24'h20, 24'h30, 24'h40};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd10);
    collect(4, 300);
    checks++;
    if (n_resp != 4) begin errors++; $display("FAIL all4_count got %0d want 4", n_resp); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_gnt[k] != k) begin errors++; $display("FAIL all4_grant[%0d] got %0d want %0d", k, got_gnt[k], k); end
      checks++;
      if (got_id[k] != k) begin errors++; $display("FAIL all4_id[%0d] got %0d want %0d", k, got_id[k], k); end
      checks++;
      if (got_out[k] !== exp_out[k] || got_bcd[k] !== exp_bcd[k]) begin
        errors++;
        $display("FAIL all4_data[%0d] got %0d/%h want %0d/%h", k, got_out[k], got_bcd[k], exp_out[k], exp_bcd[k]);
      end
      checks++;
      if (pulses[k] != 1) begin errors++; $display("FAIL all4_pulses[%0d] got %0d want 1", k, pulses[k]); end
    end
  endtask

  task automatic test_wrap();
    set_req(0, 8'd3, 8'd7);
    set_req(2, 8'd9, 8'd9);
    collect(2, 200);
    checks++;
    if (got_gnt[0] != 0 || got_gnt[1] != 2) begin
      errors++; $display("FAIL wrap_order got %0d,%0d want 0,2", got_gnt[0], got_gnt[1]);
    end
    checks++;
    if (got_out[0] !== 16'd21 || got_out[1] !== 16'd81 || got_bcd[1] !== 24'h000081) begin
      errors++; $display("FAIL wrap_data got %0d,%0d bcd %h want 21,81 bcd 000081", got_out[0], got_out[1], got_bcd[1]);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    resp_ready = 1'b0;
    set_req(1, 8'd12, 8'd12);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(3, 8'd255, 8'd255);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_wait got no resp_valid within 40 cycles"); end
    @(posedge clk); #1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_out !== 16'd144 ||
          resp_bcd !== 24'h000144 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rv=%b id=%0d out=%0d bcd=%h ready=%b want 1/1/144/000144/0000",
                 h, resp_valid, resp_id, resp_out, resp_bcd, req_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_last got %b want 1", resp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_bubble got rv=%b ready=%b want 0/1000", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    collect(1, 60);
    checks++;
    if (got_id[0] != 3 || got_out[0] !== 16'd65025 || got_bcd[0] !== 24'h065025) begin
      errors++; $display("FAIL bp_next got id=%0d out=%0d bcd=%h want 3/65025/065025", got_id[0], got_out[0], got_bcd[0]);
    end
  endtask

  task automatic test_stale_finish();
    int lat;
    lat = -1;
    mul_stale = 1'b1;
    set_req(1, 8'd6, 8'd7);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL stale_latency got %0d want 4", lat); end
    checks++;
    if (resp_out !== 16'd42 || resp_bcd !== 24'h000042) begin
      errors++; $display("FAIL stale_data got %0d/%h want 42/000042", resp_out, resp_bcd);
    end
    mul_stale = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    set_req(2, 8'd5, 8'd6);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1) begin errors++; $display("FAIL midrun_running got %b want 1", mul_start); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_out, resp_bcd, resp_err, mul_a, mul_b, mul_start} !== '0) begin
      errors++;
      $display("FAIL midrun_zero got ready=%b rv=%b id=%0d out=%0d bcd=%h err=%b a=%0d b=%0d st=%b want all zero",
               req_ready, resp_valid, resp_id, resp_out, resp_bcd, resp_err, mul_a, mul_b, mul_start);
    end
    @(posedge clk); #1;
    set_req(1, 8'd2, 8'd3);
    set_req(3, 8'd4, 8'd4);
    @(posedge clk); #1;
    reset = 1'b0;
    collect(2, 200);
    checks++;
    if (got_gnt[0] != 1 || got_gnt[1] != 3) begin
      errors++; $display("FAIL midrun_order got %0d,%0d want 1,3", got_gnt[0], got_gnt[1]);
    end
    checks++;
    if (got_out[0] !== 16'd6 || got_out[1] !== 16'd16) begin
      errors++; $display("FAIL midrun_data got %0d,%0d want 6,16", got_out[0], got_out[1]);
    end
  endtask

  task automatic test_timeout();
    int lat;
    lat = -1;
    mul_hang = 1'b1;
    set_req(0, 8'd7, 8'd7);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 2 + TO) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, 2 + TO); end
    checks++;
    if (resp_err !== 1'b1 || resp_out !== '0 || resp_bcd !== '0 || resp_id !== 2'd0) begin
      errors++; $display("FAIL timeout_resp got err=%b out=%0d bcd=%h id=%0d want 1/0/0/0", resp_err, resp_out, resp_bcd, resp_id);
    end
    mul_hang = 1'b0;
    @(posedge clk); #1;
    set_req(2, 8'd10, 8'd10);
    collect(1, 60);
    checks++;
    if (got_err[0] !== 1'b0 || got_out[0] !== 16'd100) begin
      errors++; $display("FAIL timeout_recover got err=%b out=%0d want 0/100", got_err[0], got_out[0]);
    end
`else
    for (int c = 1; c <= 3 * TO; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != -1) begin errors++; $display("FAIL no_timeout got resp_valid at %0d want none", lat); end
    checks++;
    if (mul_start !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL no_timeout_state got st=%b err=%b want 1/0", mul_start, resp_err);
    end
    mul_hang = 1'b0;
    @(posedge clk); #1;
    do_reset();
`endif
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_backpressure();
    test_stale_finish();
    test_reset_mid_run();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin scheduler that shares one sequential shift-add multiplier (with binary-to-BCD output) among NREQ requesters.
- Accepts operand pairs over valid/ready, drives the multiplier's load/start/finish protocol, and returns product, BCD and requester id over a valid/ready response channel.
- Sits between client blocks and the single multiplier instance; the multiplier itself is external.

Parameters:
- N, 8, operand width; product width 2N.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester id width; must satisfy 2^IDW >= NREQ.
- BW, (((2*N)/3)+1)*4, BCD result width (24 for N=8).
- TIMEOUT, 64, RUN-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*N  flattened operand A; slice i belongs to requester i.
- req_b  in  NREQ*N  flattened operand B.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  id of the served requester.
- resp_out  out  2N  product.
- resp_bcd  out  BW  product in BCD.
- resp_err  out  1  timeout flag.
- mul_a  out  N  operand A to the multiplier.
- mul_b  out  N  operand B to the multiplier.
- mul_start  out  1  multiplier start; low = load operands, high = compute.
- mul_finish  in  1  multiplier done; out/bcd valid while high.
- mul_out  in  2N  multiplier product.
- mul_bcd  in  BW  multiplier BCD.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, rr pointer=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_out=0, resp_bcd=0, resp_err=0.
  - mul_a=0, mul_b=0, mul_start=0, timeout counter=0.
  - A reset mid-operation abandons the job with no response.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - mul_start=0.
  - If any req_valid: grant the first set bit searching upward from the pointer with wrap-around.
  - Pulse req_ready[g] for that cycle only, register mul_a/mul_b from slice g, latch id, set pointer=(g+1) mod NREQ, go to LOAD.
  - No request: stay in IDLE.
- LOAD: exactly one cycle with mul_start=0 and operands stable, so the multiplier loads. Go to RUN.
- RUN:
  - mul_start=1; operands held.
  - On the first cycle mul_finish=1, capture mul_out and mul_bcd into resp_out/resp_bcd, clear resp_err, go to RESP.
  - mul_finish high on entry to RUN is ignored for the first cycle, to guard against stale finish.
- RESP:
  - mul_start=0; resp_valid=1; resp_id/resp_out/resp_bcd held stable.
  - On resp_valid&&resp_ready, clear resp_valid and go to IDLE.
  - The next grant happens no earlier than the following cycle: one bubble.
- Requesters hold req_valid and operands until they see req_ready.
- Requests arriving while not in IDLE wait; req_ready=0 outside IDLE.
- Only one job is ever in flight; no response is reordered or dropped.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Latency with a multiplier whose finish rises N compute cycles after start:
  - grant at cycle 0, LOAD at 1, RUN at 2 .. 2+N.
  - resp_valid at cycle 3+N, assuming mul_finish is seen at cycle 2+N.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on RUN entry and increments each RUN cycle.
  - When it reaches TIMEOUT without mul_finish, go to RESP with resp_err=1, resp_out=0, resp_bcd=0, resp_id = the granted id.
  - mul_finish on the same cycle as the timeout wins (normal result, err=0).
- Undefined:
  - No counter; RUN waits indefinitely; resp_err tied 0.

Test Plan:
- Single request: requester 2 sends a=13, b=11 -> req_ready[2] pulses once; resp_valid at cycle 3+N; resp_id=2, resp_out=143, resp_bcd=0x000143, resp_err=0.
- All four requesters valid at once, each with a=i+1, b=10 -> grants in order 0,1,2,3; responses 10,20,30,40 with matching ids; exactly one req_ready pulse each.
- Pointer wrap: after serving 3, requesters 0 and 2 valid -> 0 granted first, then 2.
- Backpressure: resp_ready held low 5 cycles in RESP -> resp_valid and data stable, no new grant; on resp_ready=1 return to IDLE; next grant one cycle later.
- Reset asserted during RUN -> all outputs 0 immediately and mul_start=0; after release, a pending request from requester 1 is granted first only if the pointer rule (reset to 0) selects it.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=16, mul_finish held 0 -> resp_valid after 16 RUN cycles with resp_err=1, resp_out=0, resp_bcd=0; without the macro, resp_valid stays 0.
